// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: a DEPTH-entry circular FIFO of {pc, pc+4, ins} with flush.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards fetch straight to decode when the queue is empty.
module fetch_queue #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_WIDTH-1:0]        in_pc,
  input  logic [PC_WIDTH-1:0]        in_pc_plus4,
  input  logic [DATA_WIDTH-1:0]      in_ins,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic [PC_WIDTH-1:0]        out_pc_plus4,
  output logic [DATA_WIDTH-1:0]      out_ins,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [PC_WIDTH-1:0]   pc_plus4;
    logic [DATA_WIDTH-1:0] ins;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             empty;
  logic             bypass;
  logic             push;
  logic             pop;
  entry_t           head;

  // Handshake and head presentation; in_ready depends on state only.
  always_comb begin
    empty        = (count == '0);
    in_ready     = (count < CNT_W'(DEPTH));
    head         = mem[rd_ptr];
    out_valid    = 1'b0;
    out_pc       = '0;
    out_pc_plus4 = '0;
    out_ins      = NOP;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass = empty && in_valid && out_ready && !flush;
    if (empty && in_valid && !flush) begin
      out_valid    = 1'b1;
      out_pc       = in_pc;
      out_pc_plus4 = in_pc_plus4;
      out_ins      = in_ins;
    end
`else
    bypass = 1'b0;
`endif
    push = in_valid && in_ready && !bypass;
    pop  = !empty && out_ready;
    if (!empty) begin
      out_valid    = 1'b1;
      out_pc       = head.pc;
      out_pc_plus4 = head.pc_plus4;
      out_ins      = head.ins;
    end
  end

  // Pointers, occupancy and storage; flush keeps storage but drops every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{pc: in_pc, pc_plus4: in_pc_plus4, ins: in_ins};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
